uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, memory-mapped UART transmitter with a FIFO of configurable depth, a runtime-programmable baud divider and selectable parity and stop-bit count. It sits on the shared processor memory bus alongside the other peripherals. Decoded by an external `enable`, it drives a single `serialOut` line. It supersedes the single-byte-buffer transmitter for software that streams strings without polling per character.

## Interface
- `FIFO_DEPTH`, 16, number of byte entries; power of two, >= 2.
- `DEFAULT_DIVIDER`, 694, reset value of the divider field; bit period = divider+1 clocks (115200 baud at 80 MHz).
- `DIV_WIDTH`, 20, width of the divider field, <= 24.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: chip select from the address decoder.
- `mem_valid` in 1: bus request.
- `mem_ready` out 1: transaction done; 0 when `enable`=0.
- `mem_instr` in 1: ignored.
- `mem_wstrb` in 4: byte write strobes; all 0 means a read.
- `mem_wdata` in 32: write data.
- `mem_addr` in 32: only bits [3:2] are decoded.
- `mem_rdata` out 32: read data, combinational from `mem_addr`; 0 when `enable`=0.
- `serialOut` out 1: serial line, idle high.

## Operation
Register map, by `mem_addr[3:2]`:
- **0 TXDATA**
  - Write with `wstrb[0]` pushes `wdata[7:0]` when the FIFO is not full.
  - Write when full drops the byte and sets sticky `overflow`.
  - Read returns STATUS.
- **1 STATUS** (read): bit0 `notFull`, bit1 `empty`, bit2 `busy` (FSM not IDLE), bit3 `overflow`, others 0.
  - bit0 keeps the meaning "may write now" for existing drivers.
  - Write with `wstrb[0]` and `wdata[3]`=1 clears `overflow`.
- **2 CONTROL** (read/write)
  - Fields: [DIV_WIDTH-1:0] divider, [24] parity enable, [25] odd parity, [26] two stop bits.
  - Written only when `wstrb`=4'b1111; any other strobe is ignored.
  - Reset: divider=DEFAULT_DIVIDER, bits 24-26 = 0.
- **3 LEVEL** (read): FIFO occupancy 0..FIFO_DEPTH in the low bits; writes ignored.

Bus handshake:
- An access is accepted in a cycle where `mem_valid & enable & !rdy`.
- Side effects (push, clear, CONTROL write) occur only on the accept cycle.
- `rdy` is registered: high the cycle after accept, low the cycle after that. Each transaction gets exactly one one-cycle `mem_ready` pulse and exactly one side effect, even if `mem_valid` is held high.

Frame FSM: IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE**: `serialOut`=1. If the FIFO is non-empty:
  - pop the head into the shifter;
  - latch divider, parity and stop settings into frame-local copies;
  - load the bit timer with the divider and go to START (`serialOut`=0).
- Every non-IDLE state lasts exactly divider+1 clocks.
  - The timer counts down to 0, then the state advances and the timer reloads.
- **DATA**: 8 bits, LSB first, bit counter 7..0.
- **PARITY**: entered only if enabled. Bit is the XOR of the data bits, inverted when odd parity is selected.
- **STOP1**: `serialOut`=1. Then STOP2 if two stop bits are selected, otherwise IDLE.
- **STOP2**: `serialOut`=1, then IDLE.
- A CONTROL write mid-frame never affects the current frame. It applies from the next START.

FIFO:
- Read/write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- full = MSBs differ and the rest are equal; empty = pointers equal.
- Push when full is rejected even if a pop occurs in the same cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.

## Timing
- Reset values: `serialOut`=1, `mem_ready`=0, `mem_rdata`=0 while `enable`=0; FIFO empty; `overflow`=0; FSM IDLE; CONTROL at defaults.
- Reset mid-frame: `serialOut` returns high asynchronously and queued bytes are discarded.
- Latency for a push accepted in cycle N into an empty FIFO while IDLE:
  - LEVEL reads 1 in cycle N+1;
  - `serialOut` is low from cycle N+2.
- Back-to-back frames with a non-empty FIFO leave no idle gap: the first IDLE cycle pops the next byte.
- Frame length in clocks = (divider+1) x (1 + 8 + parity + stop bits), plus 1 IDLE cycle between frames.

## Test plan
- **Reset idle**: assert `resetn`=0 mid-frame -> `serialOut`=1 immediately; after release, STATUS reads 0x3; CONTROL reads DEFAULT_DIVIDER.
- **Basic 8N1**: CONTROL=3 (period 4 clocks), push 0x55 -> line low 4 clocks, then 1,0,1,0,1,0,1,0 each 4 clocks, high 4 clocks; `busy` clears; 41 clocks total including the IDLE cycle.
- **Parity/stop**: CONTROL=0x0700_0001, push 0x07 -> START, data 1,1,1,0,0,0,0,0, parity bit 0 (odd, three ones), two stop bits, each bit 2 clocks.
- **FIFO full/overflow**: with divider=100, push FIFO_DEPTH+2 bytes back-to-back -> LEVEL saturates at FIFO_DEPTH-1 or FIFO_DEPTH (the first byte pops into the shifter); extra bytes dropped; `overflow`=1 until cleared by a STATUS write of 0x8; transmitted bytes match accepted order across pointer wrap.
- **Handshake**: hold `mem_valid`=1 for 5 cycles on a TXDATA write -> `mem_ready` pulses once per accept; each accept pushes exactly one byte; `mem_ready`=0 whenever `enable`=0.
- **Mid-frame CONTROL**: change the divider from 3 to 7 during DATA -> current frame keeps 4-clock bits; the next frame uses 8-clock bits.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Memory-bus port bundle for the FIFO-buffered UART transmitter.
interface uart_tx_fifo_if;
  logic        enable;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: byte FIFO, programmable divider, optional parity, 1/2 stop bits.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned DEFAULT_DIVIDER = 694,
  parameter int unsigned DIV_WIDTH       = 20
) (
  input  logic          clk,
  input  logic          resetn,
  uart_tx_fifo_if.slave bus,
  output logic          serialOut
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  localparam logic [1:0] A_TXDATA  = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_CONTROL = 2'd2;

  // Bus-side registers
  logic                 rdy_q, rdy_d;
  logic                 ovf_q, ovf_d;
  logic [DIV_WIDTH-1:0] ctl_div_q, ctl_div_d;
  logic                 ctl_par_q, ctl_par_d;
  logic                 ctl_odd_q, ctl_odd_d;
  logic                 ctl_two_q, ctl_two_d;

  // FIFO storage and pointers
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;

  // Frame engine
  logic [2:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] timer_q, timer_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_bit_q, par_bit_d;
  logic [DIV_WIDTH-1:0] frm_div_q, frm_div_d;
  logic                 frm_par_q, frm_par_d;
  logic                 frm_two_q, frm_two_d;
  logic                 tx_q, tx_d;

  logic [1:0]  reg_sel;
  logic        accept, push_req, push, pop, full, empty, ovf_clr, ctl_wr;
  logic [7:0]  head;
  logic [31:0] rd_mux;
  logic        unused_bus;

  assign reg_sel  = bus.mem_addr[3:2];
  assign accept   = bus.mem_valid & bus.enable & ~rdy_q;
  assign full     = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = (wptr_q == rptr_q);
  assign push_req = accept && (reg_sel == A_TXDATA) && bus.mem_wstrb[0];
  assign push     = push_req && !full;
  assign pop      = (state_q == S_IDLE) && !empty;
  assign ovf_clr  = accept && (reg_sel == A_STATUS) && bus.mem_wstrb[0] && bus.mem_wdata[3];
  assign ctl_wr   = accept && (reg_sel == A_CONTROL) && (bus.mem_wstrb == 4'b1111);
  assign head     = mem_q[rptr_q[AW-1:0]];

  assign bus.mem_ready = rdy_q & bus.enable;
  assign bus.mem_rdata = bus.enable ? rd_mux : 32'd0;
  assign serialOut     = tx_q;

  // Address bits outside [3:2], upper data bits and the instruction flag carry no meaning here
  assign unused_bus = ^{bus.mem_instr, bus.mem_addr, bus.mem_wdata};

  // Read-data mux over the register map
  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      A_CONTROL: begin
        rd_mux[DIV_WIDTH-1:0] = ctl_div_q;
        rd_mux[24]            = ctl_par_q;
        rd_mux[25]            = ctl_odd_q;
        rd_mux[26]            = ctl_two_q;
      end
      2'd3: rd_mux[PW-1:0] = wptr_q - rptr_q;
      default: begin
        rd_mux[0] = ~full;
        rd_mux[1] = empty;
        rd_mux[2] = (state_q != S_IDLE);
        rd_mux[3] = ovf_q;
      end
    endcase
  end

  // Handshake, FIFO pointers, overflow flag and CONTROL register next state
  always_comb begin
    rdy_d     = accept;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ovf_d     = ovf_q;
    ctl_div_d = ctl_div_q;
    ctl_par_d = ctl_par_q;
    ctl_odd_d = ctl_odd_q;
    ctl_two_d = ctl_two_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (push_req && full) ovf_d = 1'b1;
    else if (ovf_clr)     ovf_d = 1'b0;
    if (ctl_wr) begin
      ctl_div_d = bus.mem_wdata[DIV_WIDTH-1:0];
      ctl_par_d = bus.mem_wdata[24];
      ctl_odd_d = bus.mem_wdata[25];
      ctl_two_d = bus.mem_wdata[26];
    end
  end

  // Frame FSM: bit timing, shifting and next serial level
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_bit_d = par_bit_q;
    frm_div_d = frm_div_q;
    frm_par_d = frm_par_q;
    frm_two_d = frm_two_q;
    tx_d      = 1'b1;

    if (state_q == S_IDLE) begin
      if (!empty) begin
        // Settings are frozen per frame so CONTROL writes only affect later frames
        shift_d   = head;
        frm_div_d = ctl_div_q;
        frm_par_d = ctl_par_q;
        frm_two_d = ctl_two_q;
        par_bit_d = (^head) ^ ctl_odd_q;
        timer_d   = ctl_div_q;
        state_d   = S_START;
      end
    end else if (timer_q != '0) begin
      timer_d = timer_q - DIV_WIDTH'(1);
    end else begin
      timer_d = frm_div_q;
      case (state_q)
        S_START: begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd7;
        end
        S_DATA: begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd0) state_d = frm_par_q ? S_PARITY : S_STOP1;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
        S_PARITY: state_d = S_STOP1;
        S_STOP1:  state_d = frm_two_q ? S_STOP2 : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ctl_div_q <= DIV_WIDTH'(DEFAULT_DIVIDER);
      ctl_par_q <= 1'b0;
      ctl_odd_q <= 1'b0;
      ctl_two_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_bit_q <= 1'b0;
      frm_div_q <= '0;
      frm_par_q <= 1'b0;
      frm_two_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      rdy_q     <= rdy_d;
      ovf_q     <= ovf_d;
      ctl_div_q <= ctl_div_d;
      ctl_par_q <= ctl_par_d;
      ctl_odd_q <= ctl_odd_d;
      ctl_two_q <= ctl_two_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_bit_q <= par_bit_d;
      frm_div_q <= frm_div_d;
      frm_par_q <= frm_par_d;
      frm_two_q <= frm_two_d;
      tx_q      <= tx_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= bus.mem_wdata[7:0];
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: register vectors, frame waveform model, corner sequences, random frames.
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned DEF_DIV = 694;

  logic clk;
  logic resetn;
  logic serial;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIVIDER(DEF_DIV), .DIV_WIDTH(20)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .serialOut(serial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.mem_addr = {28'd0, addr, 2'b00};
    bus.enable   = 1'b1;
    #1;
    data = bus.mem_rdata;
    bus.enable = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    bus.mem_addr  = {28'd0, addr, 2'b00};
    bus.mem_wdata = data;
    bus.mem_wstrb = strb;
    bus.mem_valid = 1'b1;
    bus.enable    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("write_ready", 32'(bus.mem_ready), 32'd1);
    bus.mem_valid = 1'b0;
    bus.enable    = 1'b0;
    bus.mem_wstrb = 4'd0;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    bus_write(2'd0, {24'd0, b}, 4'b0001);
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_read(addr, rd);
    check(name, rd, exp);
  endtask

  // Expected frame: start 0, 8 data bits LSB first, optional parity, 1 or 2 stop bits, then one idle cycle.
  task automatic check_frames(input int n, input int div, input bit par, input bit odd, input bit two,
                              input bit wait_first);
    bit bits[12];
    int nb;
    int ones;
    int guard;
    bit pre;
    bit ok;
    logic [7:0] b;
    for (int f = 0; f < n; f++) begin
      pre = 1'b0;
      if (f == 0 && wait_first) begin
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (serial !== 1'b0 && guard < 200);
        if (serial !== 1'b0) begin
          check("start_timeout", 32'(serial), 32'd0);
          return;
        end
        pre = 1'b1;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL model_queue: got empty expected a queued byte");
        return;
      end
      b = exp_q.pop_front();
      nb = 0;
      bits[nb] = 1'b0; nb = nb + 1;
      for (int i = 0; i < 8; i++) begin
        bits[nb] = b[i]; nb = nb + 1;
      end
      if (par) begin
        ones = $countones(b);
        bits[nb] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        nb = nb + 1;
      end
      bits[nb] = 1'b1; nb = nb + 1;
      if (two) begin
        bits[nb] = 1'b1; nb = nb + 1;
      end
      for (int j = 0; j < nb; j++) begin
        ok = 1'b1;
        for (int k = 0; k <= div; k++) begin
          if (!(pre && j == 0 && k == 0)) @(negedge clk);
          if (serial !== bits[j]) ok = 1'b0;
        end
        check($sformatf("frame%0d_byte%02h_bit%0d", f, b, j), 32'(ok), 32'd1);
      end
      @(negedge clk);
      check("idle_cycle", 32'(serial), 32'd1);
    end
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] st;
    int g;
    g = 0;
    do begin
      @(negedge clk);
      bus_read(2'd1, st);
      g++;
    end while (st != 32'h3 && g < budget);
    check("wait_idle", st, 32'h3);
  endtask

  vec_t vecs[16];

  initial begin
    logic [31:0] rd;
    logic [31:0] ctl;
    bit   rdy_m;
    int   acc;
    int   div;
    int   n;
    bit   par, odd, two;

    vecs[0]  = '{0, 2'd1, 4'h0, 32'h0,          32'h3};
    vecs[1]  = '{0, 2'd0, 4'h0, 32'h0,          32'h3};
    vecs[2]  = '{0, 2'd2, 4'h0, 32'h0,          32'(DEF_DIV)};
    vecs[3]  = '{0, 2'd3, 4'h0, 32'h0,          32'h0};
    vecs[4]  = '{1, 2'd2, 4'h3, 32'h5,          32'h0};
    vecs[5]  = '{0, 2'd2, 4'h0, 32'h0,          32'(DEF_DIV)};
    vecs[6]  = '{1, 2'd2, 4'hF, 32'h0700_0005,  32'h0};
    vecs[7]  = '{0, 2'd2, 4'h0, 32'h0,          32'h0700_0005};
    vecs[8]  = '{1, 2'd2, 4'hF, 32'hFFFF_FFFF,  32'h0};
    vecs[9]  = '{0, 2'd2, 4'h0, 32'h0,          32'h070F_FFFF};
    vecs[10] = '{1, 2'd3, 4'hF, 32'h1234,       32'h0};
    vecs[11] = '{0, 2'd3, 4'h0, 32'h0,          32'h0};
    vecs[12] = '{1, 2'd1, 4'h1, 32'h8,          32'h0};
    vecs[13] = '{0, 2'd1, 4'h0, 32'h0,          32'h3};
    vecs[14] = '{1, 2'd2, 4'hF, 32'h3,          32'h0};
    vecs[15] = '{0, 2'd2, 4'h0, 32'h0,          32'h3};

    resetn        = 1'b0;
    bus.enable    = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_wstrb = 4'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_addr  = 32'h4;
    repeat (3) @(negedge clk);
    check("reset_serial", 32'(serial), 32'd1);
    check("reset_ready", 32'(bus.mem_ready), 32'd0);
    check("reset_rdata_disabled", bus.mem_rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rdata_disabled", bus.mem_rdata, 32'd0);

    // Register-map vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    // Basic 8N1 with 4-clock bits, push latency and frame length
    push(8'h55, 1'b1);
    read_check("latency_level", 2'd3, 32'd1);
    check("latency_still_idle", 32'(serial), 32'd1);
    check_frames(1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    read_check("basic_status_after", 2'd1, 32'h3);

    // Odd parity, two stop bits, 2-clock bits
    bus_write(2'd2, 32'h0700_0001, 4'hF);
    push(8'h07, 1'b1);
    check_frames(1, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    read_check("parity_status_after", 2'd1, 32'h3);

    // Held mem_valid: one ready pulse and one push per accept
    bus_write(2'd2, 32'd3, 4'hF);
    @(negedge clk);
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'hA5;
    bus.mem_wstrb = 4'b0001;
    bus.mem_valid = 1'b1;
    bus.enable    = 1'b1;
    rdy_m = 1'b0;
    acc   = 0;
    for (int c = 0; c < 5; c++) begin
      rdy_m = !rdy_m;
      if (rdy_m) acc++;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hs_ready_c%0d", c), 32'(bus.mem_ready), 32'(rdy_m));
    end
    bus.enable = 1'b0;
    #1;
    check("hs_ready_disabled", 32'(bus.mem_ready), 32'd0);
    check("hs_rdata_disabled", bus.mem_rdata, 32'd0);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'd0;
    read_check("hs_level", 2'd3, 32'(acc - 1));
    wait_idle(400);

    // Mid-frame CONTROL change applies only to the next frame
    fork
      check_frames(1, 3, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        push(8'hC3, 1'b1);
        repeat (12) @(negedge clk);
        bus_write(2'd2, 32'd7, 4'hF);
      end
    join
    push(8'h3C, 1'b1);
    check_frames(1, 7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Overflow, sticky flag, clear, order across pointer wrap
    bus_write(2'd2, 32'd100, 4'hF);
    fork
      check_frames(1, 100, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        for (int i = 0; i < DEPTH + 2; i++) push(8'($urandom), i <= DEPTH);
        read_check("ovf_level", 2'd3, 32'(DEPTH));
        read_check("ovf_status", 2'd1, 32'hC);
        bus_write(2'd1, 32'h8, 4'b0001);
        read_check("ovf_cleared", 2'd1, 32'h4);
        bus_write(2'd2, 32'd1, 4'hF);
      end
    join
    check_frames(DEPTH, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    read_check("ovf_drained", 2'd1, 32'h3);

    // Reset mid-frame drops queue and forces line high at once
    bus_write(2'd2, 32'd3, 4'hF);
    push(8'h00, 1'b0);
    push(8'h11, 1'b0);
    repeat (6) @(negedge clk);
    check("midframe_low", 32'(serial), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_high", 32'(serial), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    read_check("rst_status", 2'd1, 32'h3);
    read_check("rst_control", 2'd2, 32'(DEF_DIV));
    read_check("rst_level", 2'd3, 32'd0);
    begin
      bit stayed_high;
      stayed_high = 1'b1;
      repeat (30) begin
        @(negedge clk);
        if (serial !== 1'b1) stayed_high = 1'b0;
      end
      check("rst_queue_discarded", 32'(stayed_high), 32'd1);
    end

    // Random configurations and back-to-back bursts
    for (int it = 0; it < 6; it++) begin
      div = $urandom_range(1, 4);
      par = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      two = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 5);
      ctl = 32'(div) | (32'(par) << 24) | (32'(odd) << 25) | (32'(two) << 26);
      bus_write(2'd2, ctl, 4'hF);
      read_check($sformatf("rnd%0d_control", it), 2'd2, ctl);
      fork
        check_frames(n, div, par, odd, two, 1'b1);
        for (int k = 0; k < n; k++) begin
          push(8'($urandom), 1'b1);
          if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
      join
      read_check($sformatf("rnd%0d_status", it), 2'd1, 32'h3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
